// File: rtl/hazard_stall_unit.sv
// Decode-stage interlock: tracks recently issued producers and stalls dependent consumers.
// Also keeps a saturating stall-cycle counter and a sticky watchdog for long stall runs.
//
// state    | meaning
// ST_IDLE  | no stall in progress; run_cnt_q held at 0
// ST_STALL | consecutive stall run in progress; run_cnt_q counts its cycles
module hazard_stall_unit #(
  parameter int ADDR_W    = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_src1,
  input  logic [ADDR_W-1:0] dec_src2,
  input  logic              dec_src1_used,
  input  logic              dec_src2_used,
  input  logic              dec_is_branch,
  input  logic              dec_is_load,
  input  logic              dec_reg_write,
  input  logic [ADDR_W-1:0] dec_dst,
  input  logic              flush,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_err
);

  localparam int D = LOAD_LAT + 1;
  localparam logic [CNT_W:0] MAX_RUN = (CNT_W+1)'(MAX_STALL);

  typedef enum logic {ST_IDLE = 1'b0, ST_STALL = 1'b1} state_t;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              reg_write;
    logic [ADDR_W-1:0] dst;
  } trk_t;

  trk_t             trk_q [D];
  trk_t             new_ent;
  state_t           state_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W:0]   run_len;
  logic [D-1:0]     hit1;
  logic [D-1:0]     hit2;
  logic             hazard;
  logic             err_q;
  logic             err_hit;

  // Branches resolve in decode, so they also wait on a plain ALU result one slot away
  // and on a load for one extra slot compared to ALU consumers.
  always_comb begin
    hazard = 1'b0;
    hit1   = '0;
    hit2   = '0;
    for (int k = 0; k < D; k++) begin
      hit1[k] = dec_src1_used && trk_q[k].valid && trk_q[k].reg_write && (dec_src1 == trk_q[k].dst);
      hit2[k] = dec_src2_used && trk_q[k].valid && trk_q[k].reg_write && (dec_src2 == trk_q[k].dst);
      if ((hit1[k] || hit2[k]) &&
          (dec_is_branch ? (k == 0 || trk_q[k].is_load)
                         : (trk_q[k].is_load && k < LOAD_LAT)))
        hazard = 1'b1;
    end
  end

  assign stall = dec_valid && !flush && hazard;

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = dec_valid && !stall && !flush;
    new_ent.is_load   = dec_is_load;
    new_ent.reg_write = dec_reg_write;
    new_ent.dst       = dec_dst;
  end

  // run_len includes the current cycle, so the watchdog shows up during the offending cycle.
  assign run_len     = {1'b0, run_cnt_q} + (CNT_W+1)'(1);
  assign err_hit     = stall && (run_len >= MAX_RUN);
  assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign stall_err = err_q || err_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < D; k++) trk_q[k] <= '0;
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      trk_q[0] <= new_ent;
      for (int k = 1; k < D; k++) trk_q[k] <= trk_q[k-1];
      stall_cnt_q <= stall_cnt_d;
      if (err_hit) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (stall) begin
            state_q   <= ST_STALL;
            run_cnt_q <= CNT_W'(1);
          end
        end
        ST_STALL: begin
          if (!stall) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
          end else if (run_cnt_q != '1) begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          run_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: two unit instances (LOAD_LAT=1 defaults, and LOAD_LAT=3/MAX_STALL=2/CNT_W=4)
// share decode inputs; the one not under test is held in reset.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       dec_valid = 1'b0;
  logic [2:0] dec_src1 = '0;
  logic [2:0] dec_src2 = '0;
  logic       dec_src1_used = 1'b0;
  logic       dec_src2_used = 1'b0;
  logic       dec_is_branch = 1'b0;
  logic       dec_is_load = 1'b0;
  logic       dec_reg_write = 1'b0;
  logic [2:0] dec_dst = '0;
  logic       flush = 1'b0;

  logic        stall_a, err_a, stall_b, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_stall_unit u_a (
    .clk(clk), .rst(rst_a), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_is_branch(dec_is_branch), .dec_is_load(dec_is_load),
    .dec_reg_write(dec_reg_write), .dec_dst(dec_dst), .flush(flush),
    .stall(stall_a), .stall_cnt(cnt_a), .stall_err(err_a)
  );

  hazard_stall_unit #(.ADDR_W(3), .LOAD_LAT(3), .CNT_W(4), .MAX_STALL(2)) u_b (
    .clk(clk), .rst(rst_b), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
    .dec_is_branch(dec_is_branch), .dec_is_load(dec_is_load),
    .dec_reg_write(dec_reg_write), .dec_dst(dec_dst), .flush(flush),
    .stall(stall_b), .stall_cnt(cnt_b), .stall_err(err_b)
  );

  typedef struct {
    string nm;
    int    d;
    logic  s;
    int    c;
    logic  e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic act_s, act_e;
  int   act_c;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      act_s = (mon_e.d == 0) ? stall_a : stall_b;
      act_e = (mon_e.d == 0) ? err_a : err_b;
      act_c = (mon_e.d == 0) ? int'(cnt_a) : int'(cnt_b);
      n_asserts++;
      if (act_s !== mon_e.s) begin
        n_fail++;
        $display("FAIL %s stall: got %0b expected %0b", mon_e.nm, act_s, mon_e.s);
      end
      n_asserts++;
      if (act_c != mon_e.c) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", mon_e.nm, act_c, mon_e.c);
      end
      n_asserts++;
      if (act_e !== mon_e.e) begin
        n_fail++;
        $display("FAIL %s stall_err: got %0b expected %0b", mon_e.nm, act_e, mon_e.e);
      end
    end
  end

  // Drives one decode cycle just after the rising edge and queues the expected outputs for it.
  task automatic cyc(input string nm, input int d, input logic ra, input logic rb,
                     input logic v, input logic [2:0] s1, input logic u1,
                     input logic [2:0] s2, input logic u2, input logic br,
                     input logic ld, input logic wr, input logic [2:0] dst, input logic fl,
                     input logic es, input int ec, input logic ee);
    exp_t x;
    @(posedge clk);
    #1;
    rst_a = ra;  rst_b = rb;
    dec_valid = v;
    dec_src1 = s1;  dec_src1_used = u1;
    dec_src2 = s2;  dec_src2_used = u2;
    dec_is_branch = br;  dec_is_load = ld;  dec_reg_write = wr;
    dec_dst = dst;  flush = fl;
    x.nm = nm;  x.d = d;  x.s = es;  x.c = ec;  x.e = ee;
    sb.push_back(x);
  endtask

  int ecnt;
  logic eerr;
  int ns;

  initial begin
    // instance A: LOAD_LAT=1
    cyc("reset",         0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    cyc("post_rst",      0, 1, 0, 1, 0, 0, 3, 1, 0, 0, 1, 6, 0, 0, 0, 0);
    cyc("nop1",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ld_r3",         0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    cyc("add_stall",     0, 1, 0, 1, 1, 1, 3, 1, 0, 0, 1, 7, 0, 1, 0, 0);
    cyc("add_go",        0, 1, 0, 1, 1, 1, 3, 1, 0, 0, 1, 7, 0, 0, 1, 0);
    cyc("nop2",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("alu_r5",        0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0);
    cyc("beq_alu_stall", 0, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc("beq_alu_go",    0, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc("ld_r5",         0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 2, 0);
    cyc("beq_ld_st0",    0, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    cyc("beq_ld_st1",    0, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    cyc("beq_ld_go",     0, 1, 0, 1, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0);
    cyc("ld_r2",         0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 4, 0);
    cyc("unused_src",    0, 1, 0, 1, 1, 1, 2, 0, 0, 0, 1, 6, 0, 0, 4, 0);
    cyc("nop3",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    cyc("ld_r4",         0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 4, 0);
    cyc("flush_hazard",  0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 1, 7, 1, 0, 4, 0);
    cyc("flush_after",   0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 1, 7, 0, 0, 4, 0);
    cyc("ld_r1",         0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 4, 0);
    cyc("alu_r2",        0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 4, 0);
    cyc("br_two_src",    0, 1, 0, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1, 4, 0);
    cyc("br_two_go",     0, 1, 0, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 5, 0);
    cyc("ld_r1b",        0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5, 0);
    cyc("ld_r2b",        0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 5, 0);
    cyc("src2_only",     0, 1, 0, 1, 1, 1, 2, 1, 0, 0, 1, 7, 0, 1, 5, 0);
    cyc("src2_go",       0, 1, 0, 1, 1, 1, 2, 1, 0, 0, 1, 7, 0, 0, 6, 0);
    cyc("ld_r3b",        0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 6, 0);
    cyc("no_valid",      0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 7, 0, 0, 6, 0);
    cyc("nop4",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);

    // instance B: LOAD_LAT=3, MAX_STALL=2, CNT_W=4; five load->branch episodes
    ecnt = 0;
    eerr = 1'b0;
    for (int ep = 0; ep < 5; ep++) begin
      cyc("b_ld_r1", 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, ecnt, eerr);
      ns = (ep == 4) ? 2 : 4;
      for (int s = 0; s < ns; s++) begin
        if (s >= 1) eerr = 1'b1;
        cyc("b_beq_stall", 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, ecnt, eerr);
        if (ecnt < 15) ecnt++;
      end
      if (ep < 4)
        cyc("b_beq_go",  1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, ecnt, eerr);
    end
    cyc("b_rst_mid",     1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("b_rst_hold",    1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("b_rst_rel",     1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("b_nop",         1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    n_asserts++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1 (legal 1..4), bubbles an ALU consumer needs after a producing load.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 SHALL have parameter MAX_STALL, default 8, watchdog limit on consecutive stall cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port dec_valid, input, 1 bit: decode stage holds a live instruction.
REQ-008 SHALL have ports dec_src1 and dec_src2, input, ADDR_W bits each: decode source addresses.
REQ-009 SHALL have ports dec_src1_used and dec_src2_used, input, 1 bit each: the corresponding source is really read (not dummy zeros).
REQ-010 SHALL have port dec_is_branch, input, 1 bit: decode instruction is a call or conditional branch that resolves in decode.
REQ-011 SHALL have ports dec_is_load and dec_reg_write, input, 1 bit each; port dec_dst, input, ADDR_W bits: decode instruction's producer info.
REQ-012 SHALL have port flush, input, 1 bit: decode instruction is killed this cycle.
REQ-013 SHALL have port stall, output, 1 bit: hold fetch/decode and inject NOP.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: total stall cycles since reset, saturating.
REQ-015 SHALL have port stall_err, output, 1 bit: sticky watchdog flag.

Function
REQ-016 SHALL keep a tracker of D = LOAD_LAT+1 entries {valid, dst, is_load, reg_write}; entry k describes the instruction issued k+1 cycles ago.
REQ-017 SHALL shift the tracker every cycle; new entry 0 = decode instruction if dec_valid && !stall && !flush, else a bubble (valid=0).
REQ-018 Source s SHALL match entry k when src_used(s) && entry.valid && entry.reg_write && src(s)==entry.dst.
REQ-019 Non-branch: stall SHALL assert when any used source matches entry k with is_load and k < LOAD_LAT.
REQ-020 Branch: stall SHALL assert when any used source matches entry 0 (any producer) or a load entry k with k <= LOAD_LAT.
REQ-021 stall SHALL be combinational from tracker state and current decode inputs, same-cycle.
REQ-022 stall SHALL be 0 whenever dec_valid=0 or flush=1; flush wins over any hazard.
REQ-023 SHALL run FSM IDLE/STALL: IDLE->STALL when stall=1 at an edge; STALL->IDLE when stall=0; STALL->STALL otherwise.
REQ-024 SHALL count consecutive stall cycles in run_cnt; cleared on entry to IDLE.
REQ-025 stall_cnt SHALL increment by 1 each cycle stall=1 and saturate at 2^CNT_W-1 without wrapping.
REQ-026 stall_err SHALL set when run_cnt reaches MAX_STALL and remain 1 until reset; stall behaviour is unaffected.
REQ-027 When both sources match different entries, the stall decision SHALL be the OR of the per-source results.

Reset
REQ-028 While rst=0, SHALL clear all tracker entries to invalid, set FSM IDLE, run_cnt=0, stall_cnt=0, stall_err=0.
REQ-029 Reset asserted mid-stall SHALL drop stall to 0 immediately (tracker empty) and discard the episode.
REQ-030 First edge after rst release SHALL see an empty tracker: no stall possible that cycle.

Verification
REQ-031 LOAD_LAT=1: load r3, then ADD reading r3 (src2_used=1) -> stall=1 for exactly 1 cycle, stall_cnt=1, ADD proceeds next cycle.
REQ-032 LOAD_LAT=1: ALU write r5, then BEQ reading r5 -> 1 stall cycle; load r5, then BEQ r5 -> 2 stall cycles; stall_cnt=3 total.
REQ-033 load r2, then instruction with src2=r2 but src2_used=0 and src1 != r2 -> stall=0.
REQ-034 load r4 then dependent ADD with flush=1 in the hazard cycle -> stall=0; tracker entry 0 becomes bubble; following cycle stall=0.
REQ-035 LOAD_LAT=3, MAX_STALL=2: load r1, then dependent branch -> 4 stall cycles, stall_err=1 from the 2nd stall cycle onward, remains 1 after episode.
REQ-036 Force stall_cnt near 2^CNT_W-1 (CNT_W=4, 16 stall cycles) -> stall_cnt holds 15; assert rst=0 mid-stall -> stall=0, stall_cnt=0, stall_err=0 asynchronously.
